// File: rtl/wb_merge_pkg.sv
// wb_merge_pkg: shared result-bus types and the sequence-number squash predicate
package wb_merge_pkg;
  localparam int SQN_W = 7;
  typedef logic [SQN_W-1:0] SqN;
  typedef enum logic [2:0] {
    FLAGS_NONE, FLAGS_BRK, FLAGS_TRAP, FLAGS_EXCEPT,
    FLAGS_FP_NX, FLAGS_FP_UF, FLAGS_FP_OF, FLAGS_FP_DZ
  } Flags;
  typedef struct packed {
    logic [31:0] result;
    logic [6:0]  tagDst;
    SqN          sqN;
    Flags        flags;
    logic        valid;
  } RES_UOp;
  typedef struct packed {
    logic taken;
    SqN   sqN;
  } BranchProv;
  typedef enum logic [1:0] {IDLE, BUFFERED, BLOCKING} merge_state_e;
  function automatic logic sqn_younger(SqN s, SqN b);
    SqN d;
    d = s - b;
    return !d[SQN_W-1] && d != '0;
  endfunction
  function automatic logic killed(BranchProv br, SqN s);
    return br.taken && sqn_younger(s, br.sqN);
  endfunction
endpackage

// File: rtl/wb_merge_if.sv
// wb_merge_if: branch, both producer ports and the shared result bus
interface wb_merge_if;
  import wb_merge_pkg::*;
  BranchProv IN_branch;
  RES_UOp    IN_aluUop;
  RES_UOp    IN_mcUop;
  logic      OUT_mcWbAvail;
  logic      OUT_aluBlock;
  RES_UOp    OUT_uop;
  modport slave (input IN_branch, IN_aluUop, IN_mcUop, output OUT_mcWbAvail, OUT_aluBlock, OUT_uop);
  modport master (output IN_branch, IN_aluUop, IN_mcUop, input OUT_mcWbAvail, OUT_aluBlock, OUT_uop);
endinterface

// File: rtl/wb_merge_res_fifo.sv
// res_fifo: circular result buffer with per-entry squash and dead-head drop
module res_fifo
  import wb_merge_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  BranchProv              branch,
  input  RES_UOp                 in_uop,
  input  logic                   pop,
  output logic                   avail,
  output logic                   pushed,
  output logic [$clog2(DEPTH):0] count,
  output RES_UOp                 head,
  output logic                   head_valid,
  output logic                   head_killed,
  output logic                   dropped
);
  localparam int AW = $clog2(DEPTH);
  RES_UOp mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW:0] rd_ptr, wr_ptr;
  assign count = wr_ptr - rd_ptr;
  // count never exceeds DEPTH, so the extra MSB alone marks full
  assign avail = !count[AW];
  assign head = mem[rd_ptr[AW-1:0]];
  assign head_valid = count != '0 && vld[rd_ptr[AW-1:0]];
  assign head_killed = killed(branch, head.sqN);
  assign dropped = count != '0 && !vld[rd_ptr[AW-1:0]];
  assign pushed = in_uop.valid && avail && !killed(branch, in_uop.sqN);
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (killed(branch, mem[i].sqN)) vld[i] <= 1'b0;
      if (pushed) begin
        mem[wr_ptr[AW-1:0]] <= in_uop;
        vld[wr_ptr[AW-1:0]] <= 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop || dropped) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/wb_merge.sv
// wb_merge: arbitrates fixed-latency and buffered multi-cycle results onto one bus
module wb_merge
  import wb_merge_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic       clk,
  input logic       rst,
  wb_merge_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX) + 1;
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  RES_UOp head, uop_nxt;
  logic [CW-1:0] count, cnt_nxt;
  logic [SW-1:0] starve;
  logic head_valid, head_killed, dropped, pushed, alu_live, pop, pop_any;
  merge_state_e state, state_nxt;
  res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk, .rst,
    .branch(bus.IN_branch),
    .in_uop(bus.IN_mcUop),
    .pop,
    .avail(bus.OUT_mcWbAvail),
    .pushed, .count, .head, .head_valid, .head_killed, .dropped
  );
  assign alu_live = bus.IN_aluUop.valid && !killed(bus.IN_branch, bus.IN_aluUop.sqN);
  assign pop = !alu_live && head_valid && !head_killed;
  assign pop_any = pop || dropped;
  assign cnt_nxt = count + CW'(pushed) - CW'(pop_any);
  assign uop_nxt = alu_live ? bus.IN_aluUop : pop ? head : '0;
  assign bus.OUT_aluBlock = state == BLOCKING;
  always_comb begin
    state_nxt = (!pop_any && starve == SMAX) ? BLOCKING : (cnt_nxt == '0) ? IDLE : BUFFERED;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      starve <= '0;
      bus.OUT_uop <= '0;
    end else begin
      state <= state_nxt;
      bus.OUT_uop <= uop_nxt;
      starve <= (pop_any || count == '0) ? '0 : (head_valid && starve != SMAX) ? starve + 1'b1 : starve;
    end
  end
endmodule

// File: tb/tb_wb_merge.sv
// tb_wb_merge: queue-based reference model with directed and randomized stimulus
module tb_wb_merge;
  import wb_merge_pkg::*;
  localparam int DEPTH = 2;
  localparam int SMAX = 4;
  typedef struct {RES_UOp u; bit alive;} ent_t;
  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;
  wb_merge_if bus();
  wb_merge #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (.clk(clk), .rst(rst), .bus(bus));
  ent_t q[$];
  RES_UOp exp_out, alu, mc;
  BranchProv br;
  bit exp_blk, armed, mc_taken;
  int st, total, bad;
  function automatic bit kill(BranchProv b, SqN s);
    int d;
    d = (int'(s) - int'(b.sqN)) & 127;
    return b.taken && d > 0 && d < 64;
  endfunction
  function automatic RES_UOp mk(bit v, int s);
    RES_UOp u;
    u = '0;
    u.valid = v;
    u.sqN = SqN'(s);
    u.result = $urandom;
    u.tagDst = 7'($urandom);
    u.flags = Flags'($urandom_range(0, 7));
    return u;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", n, act, e, $time);
    end
  endtask
  task automatic step(input logic r);
    RES_UOp nx;
    bit popped, av, alu_live, hv, blk;
    int n;
    @(negedge clk);
    if (armed) begin
      chk("uop_valid", 32'(bus.OUT_uop.valid), 32'(exp_out.valid));
      if (exp_out.valid) begin
        chk("uop_sqn", 32'(bus.OUT_uop.sqN), 32'(exp_out.sqN));
        chk("uop_result", bus.OUT_uop.result, exp_out.result);
        chk("uop_tag", 32'(bus.OUT_uop.tagDst), 32'(exp_out.tagDst));
        chk("uop_flags", 32'(bus.OUT_uop.flags), 32'(exp_out.flags));
      end
      chk("alu_block", 32'(bus.OUT_aluBlock), 32'(exp_blk));
      chk("mc_wb_avail", 32'(bus.OUT_mcWbAvail), 32'(q.size() < DEPTH));
    end
    rst = r;
    bus.IN_aluUop = alu;
    bus.IN_mcUop = mc;
    bus.IN_branch = br;
    mc_taken = 0;
    if (r) begin
      q.delete();
      st = 0;
      exp_blk = 0;
      exp_out = '0;
      mc.valid = 0;
      armed = 1;
      return;
    end
    n = q.size();
    av = n < DEPTH;
    popped = 0;
    nx = '0;
    alu_live = alu.valid && !kill(br, alu.sqN);
    if (alu_live) nx = alu;
    hv = n > 0 && q[0].alive;
    if (n > 0 && !q[0].alive) begin
      void'(q.pop_front());
      popped = 1;
    end else if (n > 0 && !alu_live && !kill(br, q[0].u.sqN)) begin
      nx = q[0].u;
      void'(q.pop_front());
      popped = 1;
    end
    blk = (st == SMAX) && !popped;
    st = (popped || n == 0) ? 0 : (hv && st < SMAX) ? st + 1 : st;
    foreach (q[i]) if (kill(br, q[i].u.sqN)) q[i].alive = 0;
    mc_taken = mc.valid && av;
    if (mc_taken && !kill(br, mc.sqN)) q.push_back('{mc, 1'b1});
    exp_out = nx;
    exp_blk = blk;
    if (mc_taken) mc.valid = 0;
  endtask
  task automatic rst_seq();
    alu = '0;
    mc = '0;
    br = '0;
    step(1);
    step(0);
    chk("rst_valid", 32'(bus.OUT_uop.valid), 0);
    chk("rst_block", 32'(bus.OUT_aluBlock), 0);
    chk("rst_avail", 32'(bus.OUT_mcWbAvail), 1);
  endtask
  initial begin
    int sq;
    rst = 1;
    alu = '0;
    mc = '0;
    br = '0;
    rst_seq();
    for (int c = 0; c < 4; c++) begin
      alu = (c < 3) ? mk(1, 5) : mk(0, 0);
      step(0);
      if (c >= 1) begin
        chk("pt_valid", 32'(bus.OUT_uop.valid), 1);
        chk("pt_sqn", 32'(bus.OUT_uop.sqN), 5);
        chk("pt_avail", 32'(bus.OUT_mcWbAvail), 1);
      end
    end
    rst_seq();
    for (int c = 0; c < 5; c++) begin
      alu = (c < 3) ? mk(1, c + 1) : mk(0, 0);
      if (c == 0) mc = mk(1, 10);
      step(0);
      if (c == 4) chk("cont_sqn", 32'(bus.OUT_uop.sqN), 10);
    end
    rst_seq();
    for (int c = 0; c < 8; c++) begin
      alu = (c < 6) ? mk(1, c + 1) : mk(0, 0);
      if (c == 0) mc = mk(1, 10);
      step(0);
      if (c == 5) chk("starve_blk5", 32'(bus.OUT_aluBlock), 0);
      if (c == 6) chk("starve_blk6", 32'(bus.OUT_aluBlock), 1);
      if (c == 7) begin
        chk("starve_blk7", 32'(bus.OUT_aluBlock), 0);
        chk("starve_sqn", 32'(bus.OUT_uop.sqN), 10);
      end
    end
    rst_seq();
    for (int c = 0; c < 10; c++) begin
      alu = (c < 6) ? mk(1, c + 1) : mk(0, 0);
      if (c <= 2) mc = mk(1, 10 + c);
      step(0);
      if (c == 2 || c == 6) chk("full_avail0", 32'(bus.OUT_mcWbAvail), 0);
      if (c == 7) chk("full_avail1", 32'(bus.OUT_mcWbAvail), 1);
      if (c >= 7) chk("full_sqn", 32'(bus.OUT_uop.sqN), 32'(c + 3));
    end
    rst_seq();
    for (int c = 0; c < 6; c++) begin
      alu = (c <= 1) ? mk(1, c + 1) : (c == 2) ? mk(1, 16) : mk(0, 0);
      if (c == 0) mc = mk(1, 10);
      if (c == 1) mc = mk(1, 20);
      br = (c == 2) ? '{taken: 1'b1, sqN: SqN'(15)} : '0;
      step(0);
      if (c == 3) chk("sq_sqn", 32'(bus.OUT_uop.sqN), 10);
      if (c >= 4) chk("sq_dropped", 32'(bus.OUT_uop.valid), 0);
    end
    rst_seq();
    for (int c = 0; c < 7; c++) begin
      alu = (c <= 1) ? mk(1, c + 1) : mk(0, 0);
      if (c <= 1) mc = mk(1, 10 + c);
      step(c == 2);
      if (c >= 3) chk("rmid_valid", 32'(bus.OUT_uop.valid), 0);
      if (c == 3) begin
        chk("rmid_avail", 32'(bus.OUT_mcWbAvail), 1);
        chk("rmid_block", 32'(bus.OUT_aluBlock), 0);
      end
    end
    rst_seq();
    sq = 0;
    for (int c = 0; c < 3000; c++) begin
      sq += $urandom_range(0, 2);
      alu = (!exp_blk && $urandom_range(0, 2) != 0) ? mk(1, sq) : mk(0, 0);
      if (!mc.valid && $urandom_range(0, 3) == 0) mc = mk(1, sq + $urandom_range(0, 2));
      br = ($urandom_range(0, 15) == 0) ? '{taken: 1'b1, sqN: SqN'(sq - $urandom_range(0, 5))} : '0;
      step($urandom_range(0, 199) == 0);
    end
    step(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
